timer_counter: RTL

//   Memory-mapped timer peripheral on the data bus downstream of the CPU memory stage.

---
 rtl/timer_counter_if.sv | 11 +
 rtl/timer_counter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/timer_counter_if.sv
// Bus port of the memory-mapped timer: CPU store/load side signals.
// The CPU drives address, byte enables and write data; the timer returns read data.
interface timer_counter_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output byteen, output wdata, input rdata);
  modport slave  (input addr, input byteen, input wdata, output rdata);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot/periodic modes and a maskable level interrupt.
// Registers: CTRL (EN, MODE, IM), PRESET, COUNT (read-only), plus one reserved word.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus,
  output logic            irq
);

  typedef enum logic [1:0] {StIdle = 2'd0, StLoad = 2'd1, StCnt = 2'd2, StInt = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;

  logic        hit, wr_any, wr_ctrl, wr_preset;
  logic        en, periodic, im;
  logic        load_cnt, dec_cnt, int_fire;
  logic        unused_addr;

  assign unused_addr = ^bus.addr[1:0];

  assign en       = ctrl_q[0];
  assign periodic = (ctrl_q[2:1] == 2'b01);
  assign im       = ctrl_q[3];

  assign hit       = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign wr_any    = hit && (bus.byteen != 4'b0000);
  assign wr_ctrl   = wr_any && (bus.addr[3:2] == 2'd0);
  assign wr_preset = wr_any && (bus.addr[3:2] == 2'd1);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en) state_d = StLoad;
      StLoad: state_d = StCnt;
      StCnt: begin
        if (!en) begin
          state_d = StIdle;
        end else if (count_q == 32'd0) begin
          state_d = StInt;
        end
      end
      StInt:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    int_fire = 1'b0;
    unique case (state_q)
      StLoad:  load_cnt = 1'b1;
      StCnt:   dec_cnt  = en && (count_q != 32'd0);
      StInt:   int_fire = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (int_fire && !periodic) ctrl_d[0] = 1'b0;
    // Bus write wins over the one-shot EN auto-clear; only lane 0 holds CTRL bits.
    if (wr_ctrl && bus.byteen[0]) ctrl_d = bus.wdata[3:0];

    preset_d = preset_q;
    if (wr_preset) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteen[i]) preset_d[8*i +: 8] = bus.wdata[8*i +: 8];
      end
    end

    count_d = count_q;
    if (load_cnt) begin
      count_d = preset_q;
    end else if (dec_cnt) begin
      count_d = count_q - 32'd1;
    end

    pending_d = pending_q;
    if (int_fire) begin
      pending_d = 1'b1;
    end else if (pending_q && periodic) begin
      pending_d = 1'b0;
    end
    // Any CTRL write, even with partial byte enables, acknowledges the interrupt.
    if (wr_ctrl) pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= 4'd0;
      preset_q  <= 32'd0;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (hit) begin
      unique case (bus.addr[3:2])
        2'd0:    bus.rdata = {28'd0, ctrl_q};
        2'd1:    bus.rdata = preset_q;
        2'd2:    bus.rdata = count_q;
        default: bus.rdata = 32'd0;
      endcase
    end
  end

  assign irq = im && pending_q;

endmodule
